// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC0809-style multi-channel sampler.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    START   = 3'd2,
    WAIT_LO = 3'd3,
    CONV    = 3'd4,
    READ    = 3'd5,
    NEXT    = 3'd6
  } adc_state_e;

  // Widest channel mask the search helper handles; NUM_CH never exceeds it.
  localparam int MAX_CH       = 8;
  localparam int DEF_TICK_DIV = 10;
  localparam int DEF_TIMEOUT  = 255;

  // First enabled channel at or after 'cur', wrapping at num_ch-1 -> 0.
  // Returns 'cur' unchanged when the mask is empty; callers gate on mask != 0.
  function automatic int next_enabled_ch(input logic [MAX_CH-1:0] mask,
                                         input int                cur,
                                         input int                num_ch);
    logic [MAX_CH-1:0] sh;
    int                idx;
    int                res;
    res = cur;
    // Scan from the far end so the closest enabled channel is the last hit.
    for (int k = num_ch - 1; k >= 0; k--) begin
      idx = (cur + k) % num_ch;
      sh  = mask >> idx;
      if (sh[0]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Clock-enable divider: one-clk tick every TICK_DIV clocks, held in reset while en=0.
module adc_tick_gen
  import adc_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Free-running 0..TICK_DIV-1 counter, restarted from 0 whenever en drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!en || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en & (r_cnt == LAST);

endmodule

// File: rtl/adc_multi_sample.sv
// Round-robin sampler for an ADC0809-style converter (ALE/START/EOC/OE handshake).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not scanning; waits for sample_enable and a non-empty mask
//   SETUP   | channel address driven, ale high
//   START   | start pulse to the converter
//   WAIT_LO | wait for synced EOC low (guards against stale EOC high)
//   CONV    | wait for synced EOC high, or give up after TIMEOUT ticks
//   READ    | OE high; data captured on the last clk of the tick
//   NEXT    | OE low; pick the next enabled channel or fall back to IDLE
module adc_multi_sample
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int CH_W     = 3,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sample_enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              EOC,
  input  logic [DATA_W-1:0] adc_data,
  output logic              ale,
  output logic [CH_W-1:0]   addr,
  output logic              start,
  output logic              OE,
  output logic [DATA_W-1:0] dout,
  output logic [CH_W-1:0]   dout_ch,
  output logic              dout_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  adc_state_e        r_state;
  adc_state_e        w_next;
  logic              w_tick;
  logic              r_eoc_meta;
  logic              r_eoc_s;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_to_hit;
  logic              w_cap;
  logic              w_to_fire;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_sel_ch;
  logic [MAX_CH-1:0] w_mask_ext;
  int                w_scan_from;

  logic              r_ale;
  logic              r_start;
  logic              r_oe;
  logic [CH_W-1:0]   r_addr;
  logic [DATA_W-1:0] r_dout;
  logic [CH_W-1:0]   r_dout_ch;
  logic              r_dout_valid;
  logic              r_timeout_err;

  adc_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rstn(rstn),
    .en  (sample_enable),
    .tick(w_tick)
  );

  // Two-flop synchroniser for the converter's asynchronous EOC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_eoc_meta <= 1'b0;
      r_eoc_s    <= 1'b0;
    end else begin
      r_eoc_meta <= EOC;
      r_eoc_s    <= r_eoc_meta;
    end
  end

  assign w_mask_ext = MAX_CH'(ch_mask);
  assign w_to_hit   = (r_to_cnt == TO_LIMIT);

  // Channel search: IDLE resumes at the pointer, NEXT moves past it.
  always_comb begin
    w_scan_from = int'(r_ch);
    if (r_state == NEXT) w_scan_from = (int'(r_ch) + 1) % NUM_CH;
    w_sel_ch = CH_W'(next_enabled_ch(w_mask_ext, w_scan_from, NUM_CH));
  end

  // Next-state decode; transitions only on tick, abort on any clk.
  always_comb begin
    w_next    = r_state;
    w_cap     = 1'b0;
    w_to_fire = 1'b0;
    if (!sample_enable) begin
      w_next = IDLE;
    end else if (w_tick) begin
      case (r_state)
        IDLE:    if (|ch_mask) w_next = SETUP;
        SETUP:   w_next = START;
        START:   w_next = WAIT_LO;
        WAIT_LO: begin
          if (!r_eoc_s) begin
            w_next = CONV;
          end else if (w_to_hit) begin
            w_next    = NEXT;
            w_to_fire = 1'b1;
          end
        end
        // EOC is checked first so a completion on the timeout tick still captures.
        CONV: begin
          if (r_eoc_s) begin
            w_next = READ;
          end else if (w_to_hit) begin
            w_next    = NEXT;
            w_to_fire = 1'b1;
          end
        end
        READ: begin
          w_next = NEXT;
          w_cap  = 1'b1;
        end
        NEXT:    w_next = (|ch_mask) ? SETUP : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_ale         <= 1'b0;
      r_start       <= 1'b0;
      r_oe          <= 1'b0;
      r_addr        <= '0;
      r_ch          <= '0;
      r_dout        <= '0;
      r_dout_ch     <= '0;
      r_dout_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_ale         <= (w_next == SETUP);
      r_start       <= (w_next == START);
      r_oe          <= (w_next == READ);
      r_dout_valid  <= w_cap;
      r_timeout_err <= w_to_fire;
      if ((w_next == SETUP) && (r_state != SETUP)) begin
        r_ch   <= w_sel_ch;
        r_addr <= w_sel_ch;
      end
      if (w_cap) begin
        r_dout    <= adc_data;
        r_dout_ch <= r_addr;
      end
    end
  end

  // Ticks spent waiting for the converter, across WAIT_LO and CONV; saturates at the limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_to_cnt <= '0;
    end else if ((r_state != WAIT_LO) && (r_state != CONV)) begin
      r_to_cnt <= '0;
    end else if (w_tick && !w_to_hit) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign ale         = r_ale;
  assign start       = r_start;
  assign OE          = r_oe;
  assign addr        = r_addr;
  assign dout        = r_dout;
  assign dout_ch     = r_dout_ch;
  assign dout_valid  = r_dout_valid;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_adc_multi_sample.sv
// Scoreboard bench for adc_multi_sample with a behavioural ADC0809 model.
module tb_adc_multi_sample;

  localparam int TD  = 4;
  localparam int TO  = 16;
  localparam int NCH = 8;
  localparam int CW  = 3;
  localparam int DW  = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           sample_enable = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic           eoc = 1'b1;
  logic [DW-1:0]  adc_data;
  logic           ale, start, OE, dout_valid, timeout_err, busy;
  logic [CW-1:0]  addr, dout_ch;
  logic [DW-1:0]  dout;

  adc_multi_sample #(
    .NUM_CH(NCH), .CH_W(CW), .DATA_W(DW), .TICK_DIV(TD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .sample_enable(sample_enable), .ch_mask(ch_mask),
    .EOC(eoc), .adc_data(adc_data), .ale(ale), .addr(addr), .start(start),
    .OE(OE), .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NCH];
  assign adc_data = OE ? mem[addr] : '0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit is_to;
    int ch;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  n_ev = 0;
  int  last_valid_cyc = 0;
  int  last_to_cyc = 0;

  task automatic push_ev(input bit is_to, input int ch, input int data);
    ev_t e;
    e.is_to = is_to; e.ch = ch; e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rstn && (dout_valid || timeout_err)) begin
      n_ev++;
      if (dout_valid) last_valid_cyc = cyc;
      if (timeout_err) last_to_cyc = cyc;
      chk("ev_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ev_kind_timeout", int'(timeout_err), int'(e.is_to));
        chk("ev_kind_valid", int'(dout_valid), int'(!e.is_to));
        if (e.is_to) chk("ev_to_ch", int'(addr), e.ch);
        else begin
          chk("ev_ch", int'(dout_ch), e.ch);
          chk("ev_data", int'(dout), e.data);
        end
      end
    end
  end

  // ---------------- pulse width / handshake monitors ----------------
  bit       pw_en = 0;
  int       pw_cnt [5];
  logic [4:0] pw_sig;
  assign pw_sig = {timeout_err, dout_valid, OE, start, ale};

  always @(negedge clk) begin
    logic [4:0] sh;
    for (int i = 0; i < 5; i++) begin
      sh = pw_sig >> i;
      if (!rstn) pw_cnt[i] = 0;
      else if (sh[0]) pw_cnt[i]++;
      else if (pw_cnt[i] != 0) begin
        if (i >= 3 || pw_en)
          chk($sformatf("pulse_width_%0d", i), pw_cnt[i], (i >= 3) ? 1 : TD);
        pw_cnt[i] = 0;
      end
    end
  end

  logic prev_ale = 1'b0;
  logic prev_start = 1'b0;
  int   ale_addr_q[$];
  int   start_fall_cyc = 0;
  int   n_start_fall = 0;

  always @(negedge clk) begin
    if (ale && !prev_ale) ale_addr_q.push_back(int'(addr));
    if (!start && prev_start) begin
      start_fall_cyc = cyc;
      n_start_fall++;
    end
    prev_ale   = ale;
    prev_start = start;
  end

  function automatic int ale_head();
    return (ale_addr_q.size() > 0) ? ale_addr_q[0] : -1;
  endfunction

  // ---------------- ADC model ----------------
  // mode 0: EOC low 1 tick after start, high 3 ticks later
  // mode 1: EOC stuck low
  // mode 2: EOC stays high 6 ticks, low 2 ticks, then high
  int mode = 0;
  int eoc_fall_cyc = 0;

  initial begin
    forever begin
      @(posedge start);
      if (mode == 0) begin
        repeat (TD) @(negedge clk);
        eoc = 1'b0;
        repeat (3 * TD) @(negedge clk);
        eoc = 1'b1;
      end else if (mode == 1) begin
        eoc = 1'b0;
      end else begin
        repeat (6 * TD) @(negedge clk);
        eoc = 1'b0;
        eoc_fall_cyc = cyc;
        repeat (2 * TD) @(negedge clk);
        eoc = 1'b1;
      end
    end
  end

  task automatic wait_events(input int k, input int budget, input string name);
    int tgt;
    int t;
    tgt = n_ev + k;
    t = 0;
    while (n_ev < tgt && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({"wait_", name}, int'(n_ev >= tgt), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ale"}, int'(ale), 0);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_oe"}, int'(OE), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_dout"}, int'(dout), 0);
    chk({tag, "_dout_ch"}, int'(dout_ch), 0);
    chk({tag, "_valid"}, int'(dout_valid), 0);
    chk({tag, "_to"}, int'(timeout_err), 0);
  endtask

  int seq2 [5] = '{2, 5, 7, 2, 5};

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int nsf;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h5A; mem[3] = 8'hC3;
    mem[4] = 8'h96; mem[5] = 8'h0F; mem[6] = 8'hE1; mem[7] = 8'h78;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single channel 0
    pw_en = 1;
    ch_mask = 8'h01;
    push_ev(0, 0, 8'hA5);
    sample_enable = 1'b1;
    wait_events(1, 400, "t1");
    sample_enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_idle_busy", int'(busy), 0);

    // 2: round-robin 2,5,7,2,5
    ale_addr_q.delete();
    ch_mask = 8'b1010_0100;
    for (int i = 0; i < 5; i++) push_ev(0, seq2[i], int'(mem[seq2[i]]));
    sample_enable = 1'b1;
    wait_events(5, 600, "t2");
    pw_en = 0;
    sample_enable = 1'b0;
    chk("t2_addr_count", int'(ale_addr_q.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (i < ale_addr_q.size()) chk($sformatf("t2_addr_seq%0d", i), ale_addr_q[i], seq2[i]);
    repeat (50) @(negedge clk);

    // 3: stuck-low EOC on channel 3 times out, scan moves on to channel 4
    mode = 1;
    eoc = 1'b0;
    ale_addr_q.delete();
    ch_mask = 8'h18;
    push_ev(1, 3, 0);
    push_ev(0, 4, int'(mem[4]));
    sample_enable = 1'b1;
    wait_events(1, 300, "t3_to");
    chk("t3_to_latency", last_to_cyc - start_fall_cyc, 17 * TD);
    chk("t3_first_addr", ale_head(), 3);
    mode = 0;
    wait_events(1, 300, "t3_next");
    sample_enable = 1'b0;
    repeat (50) @(negedge clk);

    // 4: EOC high before start must be seen low before capture
    mode = 2;
    eoc = 1'b1;
    eoc_fall_cyc = 1000000;
    ch_mask = 8'h02;
    repeat (10) @(negedge clk);
    push_ev(0, 1, int'(mem[1]));
    sample_enable = 1'b1;
    wait_events(1, 400, "t4");
    chk("t4_capture_after_eoc_low", int'(last_valid_cyc > eoc_fall_cyc), 1);
    sample_enable = 1'b0;
    repeat (50) @(negedge clk);

    // 5: abort during CONV, resume on the same channel
    mode = 0;
    ale_addr_q.delete();
    ch_mask = 8'h41;
    nsf = n_start_fall;
    sample_enable = 1'b1;
    t = 0;
    while (n_start_fall == nsf && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t5_start_seen", int'(n_start_fall != nsf), 1);
    chk("t5_first_addr", ale_head(), 6);
    repeat (3 * TD + 2) @(negedge clk);
    chk("t5_busy_before", int'(busy), 1);
    sample_enable = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy", int'(busy), 0);
    chk("t5_abort_ale", int'(ale), 0);
    chk("t5_abort_start", int'(start), 0);
    chk("t5_abort_oe", int'(OE), 0);
    repeat (30) @(negedge clk);
    ale_addr_q.delete();
    push_ev(0, 6, int'(mem[6]));
    sample_enable = 1'b1;
    wait_events(1, 400, "t5");
    chk("t5_resume_addr", ale_head(), 6);
    sample_enable = 1'b0;
    repeat (50) @(negedge clk);

    // 6: async reset in the middle of READ
    ch_mask = 8'h10;
    sample_enable = 1'b1;
    t = 0;
    while (!OE && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("t6_oe_seen", int'(OE), 1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_all_zero("t6_rst");
    ch_mask = 8'h11;
    @(negedge clk);
    ale_addr_q.delete();
    push_ev(0, 0, int'(mem[0]));
    rstn = 1'b1;
    wait_events(1, 400, "t6");
    chk("t6_restart_addr", ale_head(), 0);
    sample_enable = 1'b0;
    repeat (10) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_multi_sample.md
Name: adc_multi_sample

Overview:
- Next-generation sampler for an ADC0809-style multiplexed converter with start/ALE/EOC/OE handshake.
- Scans up to NUM_CH analog channels round-robin under an enable mask.
- Captures each conversion result with a channel tag and a one-cycle valid strobe for downstream PID/filter logic.
- Runs on a single clock with an internal sample tick (clock enable) instead of a derived clock; adds EOC synchronisation and a conversion timeout.

Parameters:
- NUM_CH, 8: number of ADC input channels (2..8).
- CH_W, 3: channel address width; must satisfy 2^CH_W >= NUM_CH.
- DATA_W, 8: ADC data width.
- TICK_DIV, 10: clk cycles per FSM tick (>= 2).
- TIMEOUT, 255: max ticks spent in CONV before abort (>= 4).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- sample_enable  in  1  level; 1 = scanning runs, 0 = synchronous abort to IDLE.
- ch_mask  in  NUM_CH  per-channel scan enable.
- EOC  in  1  ADC end-of-conversion, asynchronous to clk.
- adc_data  in  DATA_W  ADC tri-state data bus, valid while OE=1.
- ale  out  1  address latch enable to ADC.
- addr  out  CH_W  ADC channel address.
- start  out  1  conversion start pulse.
- OE  out  1  ADC output enable.
- dout  out  DATA_W  captured sample.
- dout_ch  out  CH_W  channel of dout.
- dout_valid  out  1  one-clk strobe; dout/dout_ch are new.
- timeout_err  out  1  one-clk strobe; conversion on addr timed out.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rstn=0, async): every output 0, FSM = IDLE, tick counter 0, current channel 0.
- Tick: counter 0..TICK_DIV-1; tick=1 for one clk when counter = TICK_DIV-1. All FSM transitions happen only on tick clocks; dout_valid and timeout_err are one clk wide.
- EOC: 2-FF synchroniser into clk domain. The FSM uses only the synchronised value.
- States and transitions:
  - IDLE: when sample_enable=1 and ch_mask!=0, select the first enabled channel at or after the current pointer (ascending, wrap at NUM_CH-1 -> 0), then go to SETUP. ch_mask=0 stays in IDLE.
  - SETUP: addr = selected channel, ale=1 for this tick. Next: START.
  - START: start=1, ale=0. Next: WAIT_LO.
  - WAIT_LO: wait for synced EOC=0. This prevents a stale high EOC from being taken as completion. Next: CONV.
  - CONV: wait for synced EOC=1. Next: READ.
  - READ: OE=1 for one tick. On the last clk of this tick, latch dout <= adc_data and dout_ch <= addr, and pulse dout_valid. Next: NEXT.
  - NEXT: OE=0. Pointer advances to the next enabled channel after the current one (wrap). Go to SETUP, or to IDLE if ch_mask=0.
- Registered outputs: ale/start/OE are decoded from the next state and registered, so they change in the same clk the state changes.
- addr holds stable from SETUP through READ.
- Timeout: a tick counter runs through WAIT_LO and CONV combined. When it reaches TIMEOUT, pulse timeout_err, skip READ, go to NEXT. dout is unchanged.
- Mask changes: ch_mask is sampled only at IDLE and NEXT. Changing it mid-conversion does not affect the current channel.
- sample_enable=0 in any state: on the next clk (not tick), return to IDLE with ale/start/OE=0. No dout_valid or timeout_err. dout/dout_ch keep their last values; the channel pointer is kept.
- busy = (state != IDLE).
- Latency, single channel, ADC responding immediately: 5 ticks from SETUP entry to dout_valid.
- Simultaneous events:
  - Timeout and EOC rising on the same tick: EOC wins, so the sample is captured and no timeout_err is raised.
  - rstn overrides sample_enable.

Decomposition:
- Package adc_pkg:
  - FSM state enum (IDLE, SETUP, START, WAIT_LO, CONV, READ, NEXT).
  - Helper function next_enabled_ch(mask, cur) for wrap-around priority search.
  - Default TICK_DIV/TIMEOUT constants.
- Sub-module adc_tick_gen (parameter TICK_DIV; ports clk, rstn, en, tick): a clock-enable divider, held at 0 when en=0.

Test Plan:
1. ch_mask=8'h01, TICK_DIV=4, ADC model asserts EOC low 1 tick after start, high 3 ticks later, data 8'hA5 -> dout=8'hA5, dout_ch=0, dout_valid one clk, ale/start/OE each high exactly 1 tick.
2. ch_mask=8'b1010_0100, continuous scan -> addr sequence 2,5,7,2,5; dout_ch matches; no dout_valid for masked channels.
3. EOC held low permanently, TIMEOUT=16 -> timeout_err pulses 17 ticks after start falls (1 WAIT_LO + 16 CONV ticks) on channel 3; no dout_valid; scan continues to the next channel.
4. EOC stuck high before start -> FSM waits in WAIT_LO and does not capture until EOC goes low then high.
5. sample_enable dropped during CONV -> next clk: busy=0, OE=start=ale=0, no strobe. Re-enable -> resumes at the same channel via SETUP.
6. rstn pulsed low mid-READ (asynchronously, between clk edges) -> all outputs 0 immediately; after release, scan restarts at channel 0.
